// File: rtl/whack_scorer.sv
// Whack-a-mole scorer: synchronised strike detection, 3-digit BCD score, 4-digit muxed display.
// Optional macro WHACK_MISS_PENALTY_EN makes each miss cycle in PLAY cost one point.
module whack_scorer #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] moles_i,
    input  logic [15:0] switches_i,
    input  logic        round_start_i,
    input  logic        round_end_i,
    output logic        whacked_o,
    output logic        miss_o,
    output logic [11:0] score_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o
);

    localparam int unsigned HOLES = 16;
    localparam int unsigned SCORE_W = 12;
    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [HOLES-1:0]   s1_q, s2_q, sp_q, m_q;
    logic [HOLES-1:0]   strike_c;
    logic               hit_any_c, strike_any_c;
    logic               whacked_d, miss_d;
    logic               whacked_q, miss_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   refresh_cnt_q;
    logic [1:0]         digit_idx_q;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic [3:0]         digit_val_c;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (r[3:0] != 4'd9) begin
                r[3:0] = r[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (r[7:4] != 4'd9) begin
                    r[7:4] = r[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = r[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef WHACK_MISS_PENALTY_EN
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h000) begin
            if (r[3:0] != 4'd0) begin
                r[3:0] = r[3:0] - 4'd1;
            end else begin
                r[3:0] = 4'd9;
                if (r[7:4] != 4'd0) begin
                    r[7:4] = r[7:4] - 4'd1;
                end else begin
                    r[7:4]  = 4'd9;
                    r[11:8] = r[11:8] - 4'd1;
                end
            end
        end
        return r;
    endfunction
`endif

    function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Synchroniser and edge history run in every state so stale toggles never leak into PLAY
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            s1_q <= '0;
            s2_q <= '0;
            sp_q <= '0;
            m_q  <= '0;
        end else begin
            s1_q <= switches_i;
            s2_q <= s1_q;
            sp_q <= s2_q;
            m_q  <= moles_i;
        end
    end

    assign strike_c     = s2_q ^ sp_q;
    assign hit_any_c    = |(strike_c & m_q);
    assign strike_any_c = |strike_c;

    // State register
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start request always wins
    always_comb begin
        state_d = state_q;
        if (round_start_i) begin
            state_d = PLAY;
        end else if (round_end_i && (state_q == PLAY)) begin
            state_d = DONE;
        end
    end

    // Pulse and score logic; only PLAY scores, and any hit masks the miss for that cycle
    always_comb begin
        whacked_d = 1'b0;
        miss_d    = 1'b0;
        score_d   = score_q;
        if (round_start_i) begin
            score_d = '0;
        end else if (state_q == PLAY) begin
            if (hit_any_c) begin
                whacked_d = 1'b1;
                score_d   = bcd_inc(score_q);
            end else if (strike_any_c) begin
                miss_d = 1'b1;
`ifdef WHACK_MISS_PENALTY_EN
                score_d = bcd_dec(score_q);
`else
                score_d = score_q;
`endif
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            whacked_q <= 1'b0;
            miss_q    <= 1'b0;
            score_q   <= '0;
        end else begin
            whacked_q <= whacked_d;
            miss_q    <= miss_d;
            score_q   <= score_d;
        end
    end

    // Digit scan timing
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
        end else if (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= digit_idx_q + 2'd1;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        digit_val_c = 4'd0;
        case (digit_idx_q)
            2'd0:    digit_val_c = score_q[3:0];
            2'd1:    digit_val_c = score_q[7:4];
            2'd2:    digit_val_c = score_q[11:8];
            default: digit_val_c = 4'd0;
        endcase
    end

    // Digit 3 carries the state indicator instead of a number
    always_comb begin
        an_d  = ~(4'(4'b0001 << digit_idx_q));
        seg_d = bcd_glyph(digit_val_c);
        if (digit_idx_q == 2'd3) begin
            case (state_q)
                PLAY:    seg_d = 7'b0001100;
                DONE:    seg_d = 7'b0100001;
                default: seg_d = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            seg_q <= 7'b1111111;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign whacked_o = whacked_q;
    assign miss_o    = miss_q;
    assign score_o   = score_q;
    assign seg_o     = seg_q;
    assign an_o      = an_q;

endmodule

// File: tb/tb_whack_scorer.sv
// Directed bench for whack_scorer: pulse timing, scoring, saturation, misses, state rules, display scan.
module tb_whack_scorer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] moles_i;
    logic [15:0] switches_i;
    logic        round_start_i;
    logic        round_end_i;
    logic        whacked_o;
    logic        miss_o;
    logic [11:0] score_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;

    int n_checks = 0;
    int n_fail   = 0;

    whack_scorer #(.REFRESH_DIV(4)) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .moles_i      (moles_i),
        .switches_i   (switches_i),
        .round_start_i(round_start_i),
        .round_end_i  (round_end_i),
        .whacked_o    (whacked_o),
        .miss_o       (miss_o),
        .score_o      (score_o),
        .seg_o        (seg_o),
        .an_o         (an_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        round_start_i = 1'b1;
        tick(1);
        round_start_i = 1'b0;
    endtask

    // One strike per cycle on mask, then let the pipeline drain
    task automatic run_strikes(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            switches_i = switches_i ^ mask;
            tick(1);
        end
        tick(3);
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        round_start_i = 1'b1;
        switches_i = 16'h0001;
        moles_i = 16'h0001;
        tick(2);
        n_checks++;
        if (score_o !== 12'h000) begin n_fail++; $display("FAIL reset_score: got %h want 000", score_o); end
        n_checks++;
        if (whacked_o !== 1'b0 || miss_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got whacked=%b miss=%b want 0 0", whacked_o, miss_o);
        end
        reset_i = 1'b1;
        round_start_i = 1'b0;
        tick(4);
        n_checks++;
        if (whacked_o !== 1'b0 || score_o !== 12'h000) begin
            n_fail++; $display("FAIL reset_idle: got whacked=%b score=%h want 0 000", whacked_o, score_o);
        end
    endtask

    task automatic test_single_hit();
        moles_i = 16'h0001;
        pulse_start();
        tick(2);
        switches_i = switches_i ^ 16'h0001;
        tick(2);
        n_checks++;
        if (whacked_o !== 1'b0) begin n_fail++; $display("FAIL hit_early: got %b want 0", whacked_o); end
        tick(1);
        n_checks++;
        if (whacked_o !== 1'b1 || miss_o !== 1'b0) begin
            n_fail++; $display("FAIL hit_pulse: got whacked=%b miss=%b want 1 0", whacked_o, miss_o);
        end
        n_checks++;
        if (score_o !== 12'h001) begin n_fail++; $display("FAIL hit_score: got %h want 001", score_o); end
        tick(1);
        n_checks++;
        if (whacked_o !== 1'b0) begin n_fail++; $display("FAIL hit_width: got %b want 0", whacked_o); end
    endtask

    task automatic test_multi_hit();
        moles_i = 16'h0003;
        tick(2);
        switches_i = switches_i ^ 16'h0003;
        tick(3);
        n_checks++;
        if (whacked_o !== 1'b1 || score_o !== 12'h002) begin
            n_fail++; $display("FAIL multi_hit: got whacked=%b score=%h want 1 002", whacked_o, score_o);
        end
        tick(1);
        n_checks++;
        if (whacked_o !== 1'b0 || score_o !== 12'h002) begin
            n_fail++; $display("FAIL multi_single: got whacked=%b score=%h want 0 002", whacked_o, score_o);
        end
        switches_i = switches_i ^ 16'h0021;
        tick(3);
        n_checks++;
        if (whacked_o !== 1'b1 || miss_o !== 1'b0 || score_o !== 12'h003) begin
            n_fail++;
            $display("FAIL hit_masks_miss: got whacked=%b miss=%b score=%h want 1 0 003", whacked_o, miss_o, score_o);
        end
    endtask

    task automatic test_carry_saturate();
        moles_i = 16'h0001;
        pulse_start();
        n_checks++;
        if (score_o !== 12'h000) begin n_fail++; $display("FAIL start_clear: got %h want 000", score_o); end
        run_strikes(16'h0001, 9);
        n_checks++;
        if (score_o !== 12'h009) begin n_fail++; $display("FAIL score_9: got %h want 009", score_o); end
        run_strikes(16'h0001, 1);
        n_checks++;
        if (score_o !== 12'h010) begin n_fail++; $display("FAIL carry_10: got %h want 010", score_o); end
        run_strikes(16'h0001, 989);
        n_checks++;
        if (score_o !== 12'h999) begin n_fail++; $display("FAIL score_999: got %h want 999", score_o); end
        switches_i = switches_i ^ 16'h0001;
        tick(3);
        n_checks++;
        if (whacked_o !== 1'b1 || score_o !== 12'h999) begin
            n_fail++; $display("FAIL saturate: got whacked=%b score=%h want 1 999", whacked_o, score_o);
        end
    endtask

    task automatic test_miss();
        logic [11:0] exp1;
        logic [11:0] exp2;
`ifdef WHACK_MISS_PENALTY_EN
        exp1 = 12'h009;
        exp2 = 12'h000;
`else
        exp1 = 12'h010;
        exp2 = 12'h010;
`endif
        moles_i = 16'h0001;
        pulse_start();
        run_strikes(16'h0001, 10);
        n_checks++;
        if (score_o !== 12'h010) begin n_fail++; $display("FAIL miss_setup: got %h want 010", score_o); end
        switches_i = switches_i ^ 16'h0010;
        tick(3);
        n_checks++;
        if (miss_o !== 1'b1 || whacked_o !== 1'b0 || score_o !== exp1) begin
            n_fail++;
            $display("FAIL miss_pulse: got miss=%b whacked=%b score=%h want 1 0 %h", miss_o, whacked_o, score_o, exp1);
        end
        tick(1);
        n_checks++;
        if (miss_o !== 1'b0) begin n_fail++; $display("FAIL miss_width: got %b want 0", miss_o); end
        run_strikes(16'h0010, 12);
        n_checks++;
        if (score_o !== exp2) begin n_fail++; $display("FAIL miss_floor: got %h want %h", score_o, exp2); end
    endtask

    task automatic test_idle_and_priority();
        reset_i = 1'b0;
        tick(1);
        reset_i = 1'b1;
        moles_i = 16'h00ff;
        tick(2);
        switches_i = switches_i ^ 16'h00ff;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++;
            if (whacked_o !== 1'b0 || miss_o !== 1'b0) begin
                n_fail++; $display("FAIL idle_quiet: got whacked=%b miss=%b want 0 0", whacked_o, miss_o);
            end
        end
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (whacked_o !== 1'b0 || miss_o !== 1'b0 || score_o !== 12'h000) begin
                n_fail++;
                $display("FAIL play_no_stale: got whacked=%b miss=%b score=%h want 0 0 000", whacked_o, miss_o, score_o);
            end
            tick(1);
        end
        run_strikes(16'h0001, 5);
        n_checks++;
        if (score_o !== 12'h005) begin n_fail++; $display("FAIL pre_priority: got %h want 005", score_o); end
        round_start_i = 1'b1;
        round_end_i = 1'b1;
        tick(1);
        round_start_i = 1'b0;
        round_end_i = 1'b0;
        n_checks++;
        if (score_o !== 12'h000) begin n_fail++; $display("FAIL start_wins_clear: got %h want 000", score_o); end
        run_strikes(16'h0001, 1);
        n_checks++;
        if (score_o !== 12'h001) begin n_fail++; $display("FAIL start_wins_play: got %h want 001", score_o); end
        round_end_i = 1'b1;
        tick(1);
        round_end_i = 1'b0;
        run_strikes(16'h0001, 2);
        n_checks++;
        if (score_o !== 12'h001) begin n_fail++; $display("FAIL done_frozen: got %h want 001", score_o); end
    endtask

    task automatic test_display();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        int guard;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0100001};
        moles_i = 16'h0001;
        pulse_start();
        run_strikes(16'h0001, 123);
        round_end_i = 1'b1;
        tick(1);
        round_end_i = 1'b0;
        n_checks++;
        if (score_o !== 12'h123) begin n_fail++; $display("FAIL disp_score: got %h want 123", score_o); end
        guard = 0;
        while (an_o === 4'b1110 && guard < 40) begin tick(1); guard++; end
        while (an_o !== 4'b1110 && guard < 40) begin tick(1); guard++; end
        n_checks++;
        if (guard >= 40) begin
            n_fail++; $display("FAIL disp_sync: timed out, an_o=%b want 1110", an_o);
        end else begin
            tick(1);
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (an_o !== exp_an[d] || seg_o !== exp_seg[d]) begin
                    n_fail++;
                    $display("FAIL disp_digit%0d: got an=%b seg=%b want an=%b seg=%b",
                             d, an_o, seg_o, exp_an[d], exp_seg[d]);
                end
                tick(4);
            end
        end
    endtask

    initial begin
        reset_i = 1'b0;
        moles_i = 16'h0000;
        switches_i = 16'h0000;
        round_start_i = 1'b0;
        round_end_i = 1'b0;
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_carry_saturate();
        test_miss();
        test_idle_and_priority();
        test_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
